// File: rtl/muln_vec_pkg.sv
// Shared types and helpers for the sequential bit-sliced N x N multiplier.
// Provides the FSM state encoding and the counter width calculation.
package muln_vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the partial-product counter; at least one bit even for N=1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muln_vector_seq_bitslice_adder.sv
// W-plane ripple adder built from lane-wise full adders; plane k of each
// operand is x[k*LANES +: LANES], and carries never cross lanes.
module bitslice_adder #(
  parameter int unsigned W     = 3,
  parameter int unsigned LANES = 16
) (
  input  logic [W*LANES-1:0] x,
  input  logic [W*LANES-1:0] y,
  output logic [W*LANES-1:0] s
);

  logic [LANES-1:0] c;
  logic [LANES-1:0] xp;
  logic [LANES-1:0] yp;

  always_comb begin
    c  = '0;
    s  = '0;
    xp = '0;
    yp = '0;
    for (int unsigned k = 0; k < W; k++) begin
      xp                = x[k*LANES +: LANES];
      yp                = y[k*LANES +: LANES];
      s[k*LANES +: LANES] = xp ^ yp ^ c;
      c                 = (xp & yp) | (xp & c) | (yp & c);
    end
  end

endmodule

// File: rtl/muln_vector_seq.sv
// Sequential shift-and-add multiplier over LANES bit-sliced lanes: one
// B plane per RUN cycle is ANDed with all A planes and added into acc.
module muln_vector_seq
  import muln_vec_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned LANES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*LANES-1:0]     a,
  input  logic [N*LANES-1:0]     b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N*LANES-1:0]   y
);

  localparam int unsigned CW = cnt_width(N);
  localparam int unsigned W  = N + 1;

  state_t                 state;
  logic [N*LANES-1:0]     a_r;
  logic [N*LANES-1:0]     b_r;
  logic [2*N*LANES-1:0]   acc;
  logic [2*N*LANES-1:0]   acc_next;
  logic [CW-1:0]          cnt;
  logic                   last;

  logic [LANES-1:0]       bplane;
  logic [W*LANES-1:0]     add_x;
  logic [W*LANES-1:0]     add_y;
  logic [W*LANES-1:0]     add_s;
  int unsigned            base;

  // The adder window acc[cnt .. cnt+N] slides up one plane per cycle; its top
  // plane absorbs the carry, which cannot overflow because the product is exact.
  always_comb begin
    base     = 32'(cnt) * LANES;
    bplane   = b_r[base +: LANES];
    add_x    = acc[base +: W*LANES];
    add_y    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      add_y[k*LANES +: LANES] = a_r[k*LANES +: LANES] & bplane;
    end
    acc_next = acc;
    acc_next[base +: W*LANES] = add_s;
  end

  assign last = (cnt == CW'(N - 1));

  bitslice_adder #(
    .W     (W),
    .LANES (LANES)
  ) u_add (
    .x (add_x),
    .y (add_y),
    .s (add_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      acc       <= '0;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
    end else if (clr) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last) begin
            y         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muln_vector_seq.sv
// Self-checking bench for muln_vector_seq: fixed vectors, handshake corner
// cases, and random operands against a per-lane integer product model.
module tb_muln_vector_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // Main instance N=2, LANES=16
  logic        iv2 = 1'b0, or2 = 1'b0, ir2, ov2;
  logic [31:0] a2 = '0, b2 = '0;
  logic [63:0] y2;
  // N=3, LANES=32
  logic        iv3 = 1'b0, or3 = 1'b0, ir3, ov3;
  logic [95:0] a3 = '0, b3 = '0;
  logic [191:0] y3;
  // N=1, LANES=16
  logic        iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
  logic [15:0] a1 = '0, b1 = '0;
  logic [31:0] y1;
  // N=4, LANES=1
  logic        iv4 = 1'b0, or4 = 1'b0, ir4, ov4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  y4;

  muln_vector_seq #(.N(2), .LANES(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .y(y2));
  muln_vector_seq #(.N(3), .LANES(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv3), .in_ready(ir3),
    .a(a3), .b(b3), .out_valid(ov3), .out_ready(or3), .y(y3));
  muln_vector_seq #(.N(1), .LANES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .y(y1));
  muln_vector_seq #(.N(4), .LANES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .y(y4));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-lane reference: gather lane operands as integers, multiply, scatter.
  function automatic logic [255:0] model(input int unsigned n, input int unsigned lanes,
                                         input logic [127:0] av, input logic [127:0] bv);
    logic [255:0] r;
    logic [63:0]  pa, pb, p;
    r = '0;
    for (int unsigned j = 0; j < lanes; j++) begin
      pa = '0;
      pb = '0;
      for (int unsigned k = 0; k < n; k++) begin
        pa[k] = av[k*lanes + j];
        pb[k] = bv[k*lanes + j];
      end
      p = pa * pb;
      for (int unsigned k = 0; k < 2*n; k++) r[k*lanes + j] = p[k];
    end
    return r;
  endfunction

  task automatic start2(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a2 = av; b2 = bv; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
  endtask

  task automatic wait2(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov2 && lat < 40);
  endtask

  task automatic release2();
    @(negedge clk); or2 = 1'b1;
    @(posedge clk); #1; or2 = 1'b0;
  endtask

  task automatic run2(input string nm, input logic [31:0] av, input logic [31:0] bv,
                      input logic [63:0] exp);
    int lat;
    chk({nm, "_in_ready"}, 256'(ir2), 256'(1));
    start2(av, bv);
    wait2(lat);
    chk({nm, "_latency"}, 256'(lat), 256'(2));
    chk({nm, "_y"}, 256'(y2), 256'(exp));
    release2();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] y;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    logic [63:0]  yprev;
    logic [95:0]  ra3, rb3;
    logic [15:0]  ra1, rb1;
    logic [3:0]   ra4, rb4;

    tbl[0] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, y: 64'hFFFF_0000_0000_FFFF};
    tbl[1] = '{a: {16'hFF00, 16'hF0F0}, b: {16'hCCCC, 16'hAAAA},
               y: {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0}};
    tbl[2] = '{a: 32'h0, b: 32'hFFFF_FFFF, y: 64'h0};
    tbl[3] = '{a: {16'h0000, 16'hFFFF}, b: {16'hFFFF, 16'h0000},
               y: {16'h0000, 16'h0000, 16'hFFFF, 16'h0000}};
    for (int i = 4; i < 6; i++) begin
      tbl[i].a = $urandom;
      tbl[i].b = $urandom;
      tbl[i].y = 64'(model(2, 16, 128'(tbl[i].a), 128'(tbl[i].b)));
    end

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(ir2), 256'(1));
    chk("rst_out_valid", 256'(ov2), 256'(0));
    chk("rst_y", 256'(y2), 256'(0));
    chk("rst_y3", 256'(y3), 256'(0));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run2($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].y);

    // Backpressure: hold out_ready low, offer a second operand, nothing moves
    start2(32'h1234_5678, 32'h9ABC_DEF0);
    wait2(lat);
    chk("bp_latency", 256'(lat), 256'(2));
    yprev = y2;
    chk("bp_y", 256'(y2), model(2, 16, 128'(32'h1234_5678), 128'(32'h9ABC_DEF0)));
    @(negedge clk);
    a2 = 32'hFFFF_FFFF; b2 = 32'hFFFF_FFFF; iv2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_y", 256'(y2), 256'(yprev));
      chk("bp_hold_valid", 256'(ov2), 256'(1));
      chk("bp_hold_ready", 256'(ir2), 256'(0));
    end
    @(negedge clk); iv2 = 1'b0; or2 = 1'b1;
    @(posedge clk); #1; or2 = 1'b0;
    chk("bp_release_ready", 256'(ir2), 256'(1));
    chk("bp_release_valid", 256'(ov2), 256'(0));

    // clr at cnt=1 aborts the operation; y keeps its last result
    yprev = y2;
    start2(32'hAAAA_5555, 32'h0F0F_F0F0);
    @(posedge clk); #1;
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    chk("clr_ready", 256'(ir2), 256'(1));
    chk("clr_valid", 256'(ov2), 256'(0));
    chk("clr_y", 256'(y2), 256'(yprev));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("clr_no_valid", 256'(ov2), 256'(0));
    end
    run2("after_clr", 32'h5A5A_C3C3, 32'h3C3C_A5A5,
         64'(model(2, 16, 128'(32'h5A5A_C3C3), 128'(32'h3C3C_A5A5))));

    // Async reset during RUN: reset values appear between clock edges
    start2(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 256'(ir2), 256'(1));
    chk("arst_valid", 256'(ov2), 256'(0));
    chk("arst_y", 256'(y2), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    run2("after_arst", 32'hFFFF_0001, 32'h8000_FFFF,
         64'(model(2, 16, 128'(32'hFFFF_0001), 128'(32'h8000_FFFF))));

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      run2("rand2", ra, rb, 64'(model(2, 16, 128'(ra), 128'(rb))));
    end

    // N=3 LANES=32
    for (int i = 0; i < 10; i++) begin
      ra3 = {$urandom, $urandom, $urandom};
      rb3 = {$urandom, $urandom, $urandom};
      if (i == 0) begin ra3 = '1; rb3 = '1; end
      @(negedge clk); a3 = ra3; b3 = rb3; iv3 = 1'b1;
      @(posedge clk); #1; iv3 = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov3 && lat < 40);
      chk("n3_latency", 256'(lat), 256'(3));
      chk("n3_y", 256'(y3), model(3, 32, 128'(ra3), 128'(rb3)));
      @(negedge clk); or3 = 1'b1;
      @(posedge clk); #1; or3 = 1'b0;
    end

    // N=1 LANES=16: y plane 0 = a&b, plane 1 = 0
    for (int i = 0; i < 8; i++) begin
      ra1 = 16'($urandom); rb1 = 16'($urandom);
      @(negedge clk); a1 = ra1; b1 = rb1; iv1 = 1'b1;
      @(posedge clk); #1; iv1 = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov1 && lat < 40);
      chk("n1_latency", 256'(lat), 256'(1));
      chk("n1_y", 256'(y1), 256'({16'h0, ra1 & rb1}));
      @(negedge clk); or1 = 1'b1;
      @(posedge clk); #1; or1 = 1'b0;
    end

    // N=4 LANES=1: plain scalar product
    for (int i = 0; i < 10; i++) begin
      ra4 = 4'($urandom); rb4 = 4'($urandom);
      if (i == 0) begin ra4 = 4'hF; rb4 = 4'hF; end
      @(negedge clk); a4 = ra4; b4 = rb4; iv4 = 1'b1;
      @(posedge clk); #1; iv4 = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov4 && lat < 40);
      chk("n4_latency", 256'(lat), 256'(4));
      chk("n4_y", 256'(y4), 256'(int'(ra4) * int'(rb4)));
      @(negedge clk); or4 = 1'b1;
      @(posedge clk); #1; or4 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
